// File: rtl/regfile_write_ctrl.sv
// Write-port controller for the 8x8 register file: clears every register after reset,
// then arbitrates ALU (A) and load (M) writebacks round-robin onto registered rf_* outputs.
module regfile_write_ctrl #(
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              m_valid,
  output logic              m_ready,
  input  logic [ADDR_W-1:0] m_addr,
  input  logic [DATA_W-1:0] m_data,
  output logic              rf_en,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_data,
  output logic              init_busy,
  output logic              bad_addr,
  output logic [CNT_W-1:0]  wr_count
);

  localparam logic [ADDR_W-1:0] LastIdx   = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W:0]   NumRegsW  = (ADDR_W + 1)'(NUM_REGS);
  localparam logic [ADDR_W-1:0] AddrOne   = ADDR_W'(1);
  localparam logic [CNT_W-1:0]  CntOne    = CNT_W'(1);

  typedef enum logic {StInit, StRun} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                last_m_q, last_m_d;  // 1: M held the most recent grant
  logic                rf_en_q, rf_en_d;
  logic [ADDR_W-1:0]   rf_addr_q, rf_addr_d;
  logic [DATA_W-1:0]   rf_data_q, rf_data_d;
  logic                init_busy_q, init_busy_d;
  logic                bad_addr_q, bad_addr_d;
  logic [CNT_W-1:0]    wr_count_q, wr_count_d;

  logic                grant_a, grant_m, xfer, addr_ok;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_data;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StInit;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StInit:  if (cnt_q == LastIdx) state_d = StRun;
      StRun:   state_d = StRun;
      default: state_d = StInit;
    endcase
  end

  // Handshake outputs and next values of the registered datapath
  always_comb begin
    grant_a  = a_valid & (~m_valid | last_m_q);
    grant_m  = m_valid & (~a_valid | ~last_m_q);
    a_ready  = (state_q == StRun) & ~rst & grant_a;
    m_ready  = (state_q == StRun) & ~rst & grant_m;
    xfer     = a_ready | m_ready;
    sel_addr = a_ready ? a_addr : m_addr;
    sel_data = a_ready ? a_data : m_data;
    addr_ok  = {1'b0, sel_addr} < NumRegsW;

    cnt_d       = cnt_q;
    last_m_d    = last_m_q;
    rf_en_d     = 1'b0;
    rf_addr_d   = rf_addr_q;
    rf_data_d   = rf_data_q;
    init_busy_d = init_busy_q;
    bad_addr_d  = 1'b0;
    wr_count_d  = wr_count_q;

    if (state_q == StInit) begin
      rf_en_d   = 1'b1;
      rf_addr_d = cnt_q;
      rf_data_d = '0;
      cnt_d     = cnt_q + AddrOne;
      if (cnt_q == LastIdx) begin
        cnt_d       = '0;
        init_busy_d = 1'b0;
      end
    end else if (xfer) begin
      last_m_d = m_ready;
      if (addr_ok) begin
        rf_en_d   = 1'b1;
        rf_addr_d = sel_addr;
        rf_data_d = sel_data;
        if (wr_count_q != '1) wr_count_d = wr_count_q + CntOne;
      end else begin
        bad_addr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      last_m_q    <= 1'b1;  // A wins the first tie
      rf_en_q     <= 1'b0;
      rf_addr_q   <= '0;
      rf_data_q   <= '0;
      init_busy_q <= 1'b1;
      bad_addr_q  <= 1'b0;
      wr_count_q  <= '0;
    end else begin
      cnt_q       <= cnt_d;
      last_m_q    <= last_m_d;
      rf_en_q     <= rf_en_d;
      rf_addr_q   <= rf_addr_d;
      rf_data_q   <= rf_data_d;
      init_busy_q <= init_busy_d;
      bad_addr_q  <= bad_addr_d;
      wr_count_q  <= wr_count_d;
    end
  end

  assign rf_en     = rf_en_q;
  assign rf_addr   = rf_addr_q;
  assign rf_data   = rf_data_q;
  assign init_busy = init_busy_q;
  assign bad_addr  = bad_addr_q;
  assign wr_count  = wr_count_q;

endmodule
